// File: rtl/vga_stream_out.sv
// vga_stream_out
//
// Pixel-clock consumer on the read side of the SDRAM-to-VGA line FIFO.
// It generates VGA timing (640x480@60 by default) and pops one RGB565 word
// per active pixel while streaming. The fill-level gate is evaluated only
// at the last pixel of each frame. Pixels popped while the FIFO is empty
// are blanked and counted. Sync and RGB pins are registered, with two
// cycles of latency from the counter position to the pins.
//
// Ports:
//   clk              pixel clock, shared with the FIFO read side
//   rst              synchronous reset, active-high
//   enable           stream request, sampled at the frame decision point
//   fifo_read_enable pop request (state STREAM and active region)
//   fifo_read_data   FIFO word, valid the cycle after a pop
//   fifo_empty       FIFO empty flag, sampled with the pop
//   fifo_half_full   FIFO at least half full, sampled at the decision point
//   vga_hsync/vsync  active-low sync pins
//   vga_r/g/b        RGB565 colour pins, 0 when blanked
//   frame_start      one-cycle pulse while the counters sit at (0,0)
//   streaming        high in the STREAM state
//   underflow_count  saturating count of pops made while the FIFO was empty
module vga_stream_out #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int DATA_WIDTH  = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    output logic                   fifo_read_enable,
    input  logic [DATA_WIDTH-1:0]  fifo_read_data,
    input  logic                   fifo_empty,
    input  logic                   fifo_half_full,
    output logic                   vga_hsync,
    output logic                   vga_vsync,
    output logic [4:0]             vga_r,
    output logic [5:0]             vga_g,
    output logic [4:0]             vga_b,
    output logic                   frame_start,
    output logic                   streaming,
    output logic [COUNT_WIDTH-1:0] underflow_count
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W      = $clog2(H_TOTAL);
    localparam int V_W      = $clog2(V_TOTAL);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    typedef enum logic {
        WAIT_FILL,
        STREAM
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic           h_last;
    logic           v_last;
    logic           frame_end;
    logic           active;
    logic           hsync_n;
    logic           vsync_n;

    logic           vld_p1;
    logic           empty_p1;
    logic           active_p1;
    logic           hsync_p1;
    logic           vsync_p1;

    // Saturating increment: the counter parks at all-ones.
    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // RGB565 word when the pixel carries real data, otherwise black.
    function automatic logic [15:0] pixel_or_blank(input logic show,
                                                   input logic [DATA_WIDTH-1:0] d);
        return show ? d[15:0] : 16'h0000;
    endfunction

    assign h_last    = (32'(h_cnt) == H_TOTAL - 1);
    assign v_last    = (32'(v_cnt) == V_TOTAL - 1);
    assign frame_end = h_last && v_last;
    assign active    = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
    assign hsync_n   = !((32'(h_cnt) >= HS_START) && (32'(h_cnt) < HS_END));
    assign vsync_n   = !((32'(v_cnt) >= VS_START) && (32'(v_cnt) < VS_END));

    assign fifo_read_enable = (state == STREAM) && active;
    assign streaming        = (state == STREAM);

    // Raster counters run in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_FILL;
        end else begin
            state <= state_next;
        end
    end

    // Decisions only at the last pixel of the frame, so a frame is never
    // cut short and the new state takes effect exactly at (0,0).
    always_comb begin
        state_next = state;
        if (frame_end) begin
            case (state)
                WAIT_FILL: if (enable && fifo_half_full) state_next = STREAM;
                STREAM:    if (!enable)                  state_next = WAIT_FILL;
                default:   state_next = WAIT_FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_start     <= 1'b0;
            underflow_count <= '0;
        end else begin
            frame_start <= frame_end;
            if (fifo_read_enable && fifo_empty) begin
                underflow_count <= sat_inc(underflow_count);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            empty_p1  <= 1'b0;
            active_p1 <= 1'b0;
            hsync_p1  <= 1'b1;
            vsync_p1  <= 1'b1;
            vga_hsync <= 1'b1;
            vga_vsync <= 1'b1;
            vga_r     <= '0;
            vga_g     <= '0;
            vga_b     <= '0;
        end else begin
            // stage p1: pop, empty flag and raster flags of cycle N
            vld_p1    <= fifo_read_enable;
            empty_p1  <= fifo_empty;
            active_p1 <= active;
            hsync_p1  <= hsync_n;
            vsync_p1  <= vsync_n;
            // stage p2: FIFO data of cycle N+1 joins its flags on the pins
            vga_hsync <= hsync_p1;
            vga_vsync <= vsync_p1;
            {vga_r, vga_g, vga_b} <= pixel_or_blank(vld_p1 && active_p1 && !empty_p1,
                                                    fifo_read_data);
        end
    end

endmodule

// File: doc/vga_stream_out.md
# vga_stream_out

Pixel-clock-domain consumer on the read side of the SDRAM-to-VGA line FIFO. It generates 640x480@60 VGA timing and pops one RGB565 word per active pixel from the FIFO. It gates streaming on FIFO fill level at frame boundaries, blanks and counts underflowed pixels, and drives registered sync and RGB pins.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- DATA_WIDTH, 16, FIFO word width (RGB565)
- COUNT_WIDTH, 16, underflow counter width

Ports:
- clk  in  1  pixel clock (25 MHz), same clock as the FIFO read side
- rst  in  1  synchronous reset, active-high
- enable  in  1  request to stream; sampled only at the frame decision point
- fifo_read_enable  out  1  pop request to the FIFO
- fifo_read_data  in  DATA_WIDTH  FIFO output, valid the cycle after a pop
- fifo_empty  in  1  FIFO empty flag
- fifo_half_full  in  1  FIFO holds at least half its depth
- vga_hsync  out  1  active-low hsync
- vga_vsync  out  1  active-low vsync
- vga_r  out  5  red
- vga_g  out  6  green
- vga_b  out  5  blue
- frame_start  out  1  one-cycle pulse while counters are at (0,0)
- streaming  out  1  high in STREAM state
- underflow_count  out  COUNT_WIDTH  saturating count of pops attempted while empty

## Operation
- Line and frame totals:
  - H_TOTAL = sum of the H_* parameters = 800.
  - V_TOTAL = sum of the V_* parameters = 525.
- Counters:
  - h_cnt runs 0..H_TOTAL-1. At the wrap it returns to 0 and v_cnt increments.
  - v_cnt runs 0..V_TOTAL-1, then wraps to 0.
  - Counters run in every state.
- Region order per line and per frame is active, front porch, sync, back porch.
  - Active: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
  - hsync low for h_cnt in [656,751].
  - vsync low for v_cnt in [490,491].
- States:
  - WAIT_FILL is the reset state. No pops; RGB outputs are 0.
  - STREAM.
- Frame decision point: the cycle with h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1. The new state applies from (0,0).
  - WAIT_FILL -> STREAM when enable=1 and fifo_half_full=1.
  - STREAM -> WAIT_FILL when enable=0.
  - No other transitions. fifo_empty never changes state.
- fifo_read_enable is combinational from registered state and counters: STREAM and active.
- Underflow:
  - A pop cycle with fifo_empty=1 is an underflow. Its pixel is output as 0.
  - underflow_count increments, saturating at all-ones.
  - Streaming continues.
- RGB565 decode: r=data[15:11], g=data[10:5], b=data[4:0].
- RGB outputs are 0 outside the active region and in WAIT_FILL.

## Timing
- Pipeline is 2 cycles from counter position to pins.
- Counter cycle N, pixel active in STREAM:
  - fifo_read_enable=1 in cycle N.
  - The empty flag is sampled into the pipe in cycle N.
  - fifo_read_data is valid in cycle N+1.
  - Pins are registered at the end of N+1, so RGB appears on pins in cycle N+2.
- hsync, vsync and the active flag pass through the same 2 registers, so pins stay aligned.
- frame_start:
  - Registered, high exactly in the cycle where counters are (0,0), i.e. 2 cycles before pixel (0,0) reaches the pins.
  - Not asserted in the first cycle after reset release. The first pulse comes 420000 cycles after release.
- Reset values (one clk edge with rst=1):
  - h_cnt=0, v_cnt=0, state WAIT_FILL.
  - Pins: vga_hsync=1, vga_vsync=1, RGB=0.
  - Status: frame_start=0, streaming=0, underflow_count=0.
  - fifo_read_enable=0, since it derives from the WAIT_FILL state.
- First decision point is 419999 cycles after reset release, so at least one full blank frame follows reset.
- Reset mid-frame: all registers reset on the next edge; the pipe is flushed; timing restarts at (0,0).
- enable and fifo_half_full are ignored except at the decision point.
  - Dropping enable mid-frame finishes the frame: all remaining active pixels are still popped.
- Each STREAM frame pops exactly 307200 words: 640 per active line.

## Test plan
- Reset: hold rst 3 cycles, then release.
  - First vga_hsync low 658 cycles after release, lasting 96 cycles; line period 800.
  - vga_vsync low for 1600 cycles starting at line 490 (+2 cycles).
  - RGB=0 and fifo_read_enable=0 for the whole first frame.
- Fill gate: enable=1.
  - fifo_half_full=0 at the first decision point -> no pops in frame 2.
  - Raise fifo_half_full -> streaming=1 and the first pop at (0,0) of frame 3.
  - 307200 pops counted per frame.
- Alignment: behavioural FIFO returning 0xF800, 0x07E0, 0x001F, ... -> pixel 0 on pins 2 cycles after its pop with r=31,g=0,b=0; pixel 1 g=63; pixel 2 b=31.
- Underflow: force fifo_empty=1 for 5 active cycles mid-line.
  - Exactly those 5 pixels are 0.
  - underflow_count=5.
  - Neighbouring pixels are correct.
- Saturation with COUNT_WIDTH=4: 20 underflow pops -> underflow_count=15 and stays 15.
- Mid-operation events:
  - enable dropped at line 100 -> pops continue through line 479; streaming falls at the decision point.
  - rst pulsed mid-line in a later frame -> next cycle shows all reset values; hsync timing restarts from 0.
